// File: rtl/vec_load_sequencer.sv
// Sequenced vector load engine: one memory request per active element, results
// assembled into a VLEN-wide destination with undisturbed tail/mask policy.
//
// state  | meaning
// IDLE   | waiting for start; vd_data holds the last result
// LOAD   | walking elements 0..evl-1, one outstanding request at a time
// DONE   | is_loaded pulse, back to IDLE
// ERR    | err pulse for an illegal mode/width, back to IDLE
module vec_load_sequencer #(
    parameter int XLEN   = 32,
    parameter int VLEN   = 512,
    parameter int MEM_DW = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [2:0]        width,
    input  logic [XLEN-1:0]   base_addr,
    input  logic [XLEN-1:0]   stride,
    input  logic [VLEN-1:0]   index_data,
    input  logic [XLEN-1:0]   vl,
    input  logic              vm,
    input  logic [VLEN-1:0]   v0_mask,
    input  logic [VLEN-1:0]   old_vd,
    output logic              mem_req,
    output logic [XLEN-1:0]   mem_addr,
    input  logic              mem_rvalid,
    input  logic [MEM_DW-1:0] mem_rdata,
    output logic              busy,
    output logic              is_loaded,
    output logic              err,
    output logic [VLEN-1:0]   vd_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam int IW = $clog2(VLEN / 8 + 1);
    localparam int VW = $clog2(VLEN);

    function automatic logic [31:0] f_emask(input logic [5:0] eew);
        case (eew)
            6'd8:    f_emask = 32'h0000_00FF;
            6'd16:   f_emask = 32'h0000_FFFF;
            default: f_emask = 32'hFFFF_FFFF;
        endcase
    endfunction

    logic [1:0]      r_state;
    logic [1:0]      r_mode;
    logic [5:0]      r_eew;
    logic [XLEN-1:0] r_base;
    logic [XLEN-1:0] r_stride;
    logic [XLEN-1:0] r_acc;
    logic [VLEN-1:0] r_index;
    logic [VLEN-1:0] r_mask;
    logic            r_vm;
    logic [IW-1:0]   r_evl;
    logic [IW-1:0]   r_idx;
    logic            r_mem_req;
    logic [XLEN-1:0] r_mem_addr;
    logic            r_busy;
    logic            r_is_loaded;
    logic            r_err;
    logic [VLEN-1:0] r_vd;

    logic [5:0]      w_in_eew;
    logic [IW-1:0]   w_in_nelem;
    logic            w_legal;
    logic [IW-1:0]   w_evl;
    logic [31:0]     w_m32_in;
    logic [XLEN-1:0] w_addr0;
    logic            w_act0;
    logic [31:0]     w_m32;
    logic [IW-1:0]   w_idx_nxt;
    logic [VW-1:0]   w_mask_idx;
    logic            w_last;
    logic [31:0]     w_sh_cur;
    logic [31:0]     w_sh_nxt;
    logic [XLEN-1:0] w_step;
    logic [XLEN-1:0] w_acc_nxt;
    logic [XLEN-1:0] w_idx_val;
    logic [XLEN-1:0] w_addr_nxt;
    logic            w_act_nxt;
    logic [VLEN-1:0] w_slot;
    logic [VLEN-1:0] w_elem;
    logic            w_adv;

    always_comb begin
        w_in_eew   = 6'd8;
        w_in_nelem = IW'(VLEN / 8);
        case (width)
            3'b101: begin
                w_in_eew   = 6'd16;
                w_in_nelem = IW'(VLEN / 16);
            end
            3'b110: begin
                w_in_eew   = 6'd32;
                w_in_nelem = IW'(VLEN / 32);
            end
            default: ;
        endcase
        w_legal = (mode != 2'b11) && (width == 3'b000 || width == 3'b101 || width == 3'b110);
        w_evl   = (vl < XLEN'(w_in_nelem)) ? IW'(vl) : w_in_nelem;

        // Element 0 is prepared during the capture edge so LOAD starts requesting in cycle 1.
        w_m32_in = f_emask(w_in_eew);
        w_addr0  = (mode == 2'b10) ? base_addr + XLEN'(index_data[31:0] & w_m32_in) : base_addr;
        w_act0   = vm | v0_mask[0];

        w_m32      = f_emask(r_eew);
        w_idx_nxt  = r_idx + IW'(1);
        w_mask_idx = VW'(w_idx_nxt);
        w_last     = (w_idx_nxt == r_evl);
        w_sh_cur   = 32'(r_idx) * 32'(r_eew);
        w_sh_nxt   = 32'(w_idx_nxt) * 32'(r_eew);

        // The accumulator steps on every element, skipped ones included.
        w_step     = (r_mode == 2'b01) ? r_stride : XLEN'(r_eew >> 3);
        w_acc_nxt  = r_acc + w_step;
        w_idx_val  = XLEN'(32'(r_index >> w_sh_nxt) & w_m32);
        w_addr_nxt = (r_mode == 2'b10) ? r_base + w_idx_val : w_acc_nxt;
        w_act_nxt  = r_vm | r_mask[w_mask_idx];

        w_slot = VLEN'(w_m32) << w_sh_cur;
        w_elem = VLEN'(mem_rdata[31:0] & w_m32) << w_sh_cur;
        w_adv  = !r_mem_req || mem_rvalid;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_mode      <= '0;
            r_eew       <= '0;
            r_base      <= '0;
            r_stride    <= '0;
            r_acc       <= '0;
            r_index     <= '0;
            r_mask      <= '0;
            r_vm        <= 1'b0;
            r_evl       <= '0;
            r_idx       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_busy      <= 1'b0;
            r_is_loaded <= 1'b0;
            r_err       <= 1'b0;
            r_vd        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode   <= mode;
                        r_eew    <= w_in_eew;
                        r_base   <= base_addr;
                        r_stride <= stride;
                        r_acc    <= base_addr;
                        r_index  <= index_data;
                        r_mask   <= v0_mask;
                        r_vm     <= vm;
                        r_evl    <= w_evl;
                        r_idx    <= '0;
                        r_vd     <= old_vd;
                        r_busy   <= 1'b1;
                        if (!w_legal) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else if (w_evl == '0) begin
                            r_is_loaded <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mem_req  <= w_act0;
                            r_mem_addr <= w_addr0;
                            r_state    <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (w_adv) begin
                        r_idx <= w_idx_nxt;
                        r_acc <= w_acc_nxt;
                        if (r_mem_req) begin
                            r_vd <= (r_vd & ~w_slot) | w_elem;
                        end
                        if (w_last) begin
                            r_mem_req   <= 1'b0;
                            r_is_loaded <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mem_req  <= w_act_nxt;
                            r_mem_addr <= w_addr_nxt;
                        end
                    end
                end
                default: begin
                    r_is_loaded <= 1'b0;
                    r_err       <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_addr  = r_mem_addr;
    assign busy      = r_busy;
    assign is_loaded = r_is_loaded;
    assign err       = r_err;
    assign vd_data   = r_vd;

endmodule

// File: tb/tb_vec_load_sequencer.sv
// Directed bench for vec_load_sequencer: table of load vectors with hand-computed
// addresses, cycle counts and element values, plus hold/reset/clamp sequences.
module tb_vec_load_sequencer;

    localparam int XLEN = 32;
    localparam int VLEN = 512;
    localparam int MEM_DW = 32;
    localparam int NV = 9;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              start = 1'b0;
    logic [1:0]        mode = '0;
    logic [2:0]        width = '0;
    logic [XLEN-1:0]   base_addr = '0;
    logic [XLEN-1:0]   stride = '0;
    logic [VLEN-1:0]   index_data = '0;
    logic [XLEN-1:0]   vl = '0;
    logic              vm = 1'b0;
    logic [VLEN-1:0]   v0_mask = '0;
    logic [VLEN-1:0]   old_vd = '0;
    logic              mem_req;
    logic [XLEN-1:0]   mem_addr;
    logic              mem_rvalid = 1'b0;
    logic [MEM_DW-1:0] mem_rdata = '0;
    logic              busy;
    logic              is_loaded;
    logic              err;
    logic [VLEN-1:0]   vd_data;

    int total = 0;
    int bad = 0;
    logic [VLEN-1:0] OLD;
    logic [31:0] q_addr[$];

    vec_load_sequencer #(.XLEN(XLEN), .VLEN(VLEN), .MEM_DW(MEM_DW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .mode(mode), .width(width),
        .base_addr(base_addr), .stride(stride), .index_data(index_data), .vl(vl),
        .vm(vm), .v0_mask(v0_mask), .old_vd(old_vd), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .is_loaded(is_loaded), .err(err), .vd_data(vd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  md;
        logic [2:0]  wd;
        logic [31:0] ba;
        logic [31:0] st;
        logic [31:0] vl;
        logic        vm;
        logic [15:0] msk;
        logic [15:0] i0;
        logic [15:0] i1;
        int          dly;
        logic [15:0] hi;
        int          cyc;
        logic        eerr;
        int          nhs;
        int          reqc;
        logic [31:0] a0, a1, a2, a3;
        logic [3:0]  wm;
        logic [31:0] e0, e1, e2, e3;
    } vec_t;

    vec_t tbl[NV];

    task automatic chk(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [VLEN-1:0] mk_idx(input logic [2:0] wd, input logic [15:0] a, input logic [15:0] b);
        logic [VLEN-1:0] r;
        r = '0;
        case (wd)
            3'b000:  begin r[7:0] = a[7:0]; r[15:8] = b[7:0]; end
            3'b101:  r[31:0] = {b, a};
            default: begin r[31:0] = {16'h0, a}; r[63:32] = {16'h0, b}; end
        endcase
        return r;
    endfunction

    function automatic logic [VLEN-1:0] mk_exp(input logic [2:0] wd, input logic [3:0] wm,
                                               input logic [31:0] e0, input logic [31:0] e1,
                                               input logic [31:0] e2, input logic [31:0] e3);
        logic [VLEN-1:0] r;
        logic [31:0] ev[4];
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        r = OLD;
        for (int k = 0; k < 4; k++) begin
            if (wm[k]) begin
                case (wd)
                    3'b000:  r[k*8 +: 8] = ev[k][7:0];
                    3'b101:  r[k*16 +: 16] = ev[k][15:0];
                    default: r[k*32 +: 32] = ev[k];
                endcase
            end
        end
        return r;
    endfunction

    // Drives one start, serves memory with optional wait states, and scrambles the
    // inputs after the capture edge; returns timing and handshake statistics.
    task automatic do_load(input logic [1:0] md, input logic [2:0] wd, input logic [31:0] ba,
                           input logic [31:0] st, input logic [VLEN-1:0] idx, input logic [31:0] vli,
                           input logic vmi, input logic [VLEN-1:0] msk, input int dly,
                           input logic [15:0] hi, input int hold,
                           output int done_cyc, output logic was_err, output int nhs,
                           output int nreqc, output int unstable, output int pulses);
        int wait_cnt;
        logic prev_req, prev_hs;
        logic [31:0] prev_addr;
        @(negedge clk);
        mode = md; width = wd; base_addr = ba; stride = st; index_data = idx;
        vl = vli; vm = vmi; v0_mask = msk; old_vd = OLD; start = 1'b1;
        q_addr.delete();
        done_cyc = -1; was_err = 1'b0; nhs = 0; nreqc = 0; unstable = 0; pulses = 0;
        wait_cnt = 0; prev_req = 1'b0; prev_hs = 1'b0; prev_addr = '0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (c > hold) start = 1'b0;
            if (c == 1) begin
                base_addr = 32'h0BAD_0000; stride = 32'd7; vl = 32'd1; vm = ~vmi;
                v0_mask = ~msk; old_vd = ~OLD; index_data = ~idx;
                chk("busy_c1", busy, 1);
            end
            if (is_loaded || err) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    was_err = err;
                end
            end
            if (mem_req) begin
                nreqc++;
                if (prev_req && !prev_hs && mem_addr != prev_addr) unstable++;
            end
            if (mem_req && wait_cnt >= dly) begin
                mem_rvalid = 1'b1;
                mem_rdata = {hi, 16'h0} ^ (mem_addr + 32'd1);
                q_addr.push_back(mem_addr);
                nhs++;
                wait_cnt = 0;
                prev_hs = 1'b1;
            end else begin
                mem_rvalid = !mem_req;
                mem_rdata = 32'hDEAD_BEEF;
                if (mem_req) wait_cnt++;
                prev_hs = 1'b0;
            end
            prev_req = mem_req;
            prev_addr = mem_addr;
            if (done_cyc > 0 && c == done_cyc + 1) break;
        end
        start = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    initial begin
        vec_t v;
        int dc, nh, nr, un, pu;
        logic we;
        logic [31:0] ea[4];
        logic [VLEN-1:0] ex;
        string nm;

        for (int k = 0; k < VLEN / 32; k++) OLD[k*32 +: 32] = 32'hC0DE_A55A + 32'(k);

        //           md    wd      ba          st            vl     vm    msk     i0      i1     dly hi
        //           cyc eerr nhs reqc a0..a3                                        wm    e0..e3
        tbl[0] = '{2'd0, 3'b110, 32'h100,  32'h0,        32'd4, 1'b1, 16'h0, 16'h0,  16'h0,  0, 16'h0,
                   5, 1'b0, 4, 4, 32'h100, 32'h104, 32'h108, 32'h10C, 4'hF, 32'h101, 32'h105, 32'h109, 32'h10D};
        tbl[1] = '{2'd1, 3'b000, 32'h20,   32'h3,        32'd4, 1'b0, 16'h5, 16'h0,  16'h0,  0, 16'hBEEF,
                   5, 1'b0, 2, 2, 32'h20, 32'h26, 32'h0, 32'h0, 4'h5, 32'h21, 32'h0, 32'h27, 32'h0};
        tbl[2] = '{2'd2, 3'b101, 32'h1000, 32'h0,        32'd2, 1'b1, 16'h0, 16'h10, 16'h02, 2, 16'hBEEF,
                   7, 1'b0, 2, 6, 32'h1010, 32'h1002, 32'h0, 32'h0, 4'h3, 32'h1011, 32'h1003, 32'h0, 32'h0};
        tbl[3] = '{2'd0, 3'b110, 32'h100,  32'h0,        32'd0, 1'b1, 16'h0, 16'h0,  16'h0,  0, 16'h0,
                   1, 1'b0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[4] = '{2'd0, 3'b011, 32'h100,  32'h0,        32'd4, 1'b1, 16'h0, 16'h0,  16'h0,  0, 16'h0,
                   1, 1'b1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[5] = '{2'd3, 3'b110, 32'h100,  32'h0,        32'd4, 1'b1, 16'h0, 16'h0,  16'h0,  0, 16'h0,
                   1, 1'b1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        tbl[6] = '{2'd0, 3'b101, 32'h40,   32'h0,        32'd3, 1'b1, 16'h0, 16'h0,  16'h0,  0, 16'hBEEF,
                   4, 1'b0, 3, 3, 32'h40, 32'h42, 32'h44, 32'h0, 4'h7, 32'h41, 32'h43, 32'h45, 32'h0};
        tbl[7] = '{2'd1, 3'b110, 32'h200,  32'hFFFF_FFF8, 32'd3, 1'b0, 16'h6, 16'h0,  16'h0,  0, 16'h0,
                   4, 1'b0, 2, 2, 32'h1F8, 32'h1F0, 32'h0, 32'h0, 4'h6, 32'h0, 32'h1F9, 32'h1F1, 32'h0};
        tbl[8] = '{2'd2, 3'b000, 32'h300,  32'h0,        32'd2, 1'b0, 16'h3, 16'hFF, 16'h05, 0, 16'hBEEF,
                   3, 1'b0, 2, 2, 32'h3FF, 32'h305, 32'h0, 32'h0, 4'h3, 32'h0, 32'h6, 32'h0, 32'h0};

        @(negedge clk);
        chk("rst_outputs", {mem_req, busy, is_loaded, err}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_vd", vd_data, 0);
        @(negedge clk);
        n_rst = 1'b1;

        for (int k = 0; k < NV; k++) begin
            v = tbl[k];
            do_load(v.md, v.wd, v.ba, v.st, mk_idx(v.wd, v.i0, v.i1), v.vl, v.vm, VLEN'(v.msk),
                    v.dly, v.hi, 0, dc, we, nh, nr, un, pu);
            nm = $sformatf("v%0d", k);
            chk({nm, "_cyc"}, dc, v.cyc);
            chk({nm, "_err"}, we, v.eerr);
            chk({nm, "_handshakes"}, nh, v.nhs);
            chk({nm, "_req_cycles"}, nr, v.reqc);
            chk({nm, "_addr_stable"}, un, 0);
            chk({nm, "_pulses"}, pu, 1);
            chk({nm, "_busy_after"}, busy, 0);
            ex = mk_exp(v.wd, v.wm, v.e0, v.e1, v.e2, v.e3);
            chk({nm, "_vd"}, vd_data, ex);
            ea[0] = v.a0; ea[1] = v.a1; ea[2] = v.a2; ea[3] = v.a3;
            for (int j = 0; j < v.nhs && j < 4; j++) begin
                if (j < q_addr.size()) chk($sformatf("%s_addr%0d", nm, j), q_addr[j], ea[j]);
            end
        end

        // vl far above nelem: clamped to 16 words.
        do_load(2'd0, 3'b110, 32'h0, 32'h0, '0, 32'd1000, 1'b1, '0, 0, 16'h0, 0, dc, we, nh, nr, un, pu);
        chk("clamp_cyc", dc, 17);
        chk("clamp_handshakes", nh, 16);
        if (q_addr.size() == 16) chk("clamp_last_addr", q_addr[15], 32'h3C);
        for (int k = 0; k < 16; k++) ex[k*32 +: 32] = 32'(4 * k + 1);
        chk("clamp_vd", vd_data, ex);

        // start held high while busy, with scrambled inputs, must not spawn a second load.
        do_load(2'd0, 3'b110, 32'h100, 32'h0, '0, 32'd4, 1'b1, '0, 0, 16'h0, 2, dc, we, nh, nr, un, pu);
        chk("hold_cyc", dc, 5);
        chk("hold_handshakes", nh, 4);
        chk("hold_pulses", pu, 1);
        if (q_addr.size() == 4) chk("hold_addr3", q_addr[3], 32'h10C);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_idle", {busy, mem_req}, 0);
        end

        // Asynchronous reset during the third element, with a response still in flight.
        @(negedge clk);
        mode = 2'd0; width = 3'b110; base_addr = 32'h100; vl = 32'd4; vm = 1'b1;
        old_vd = OLD; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) chk("rst_pre_addr", mem_addr, 32'h108);
            mem_rvalid = mem_req;
            mem_rdata = mem_addr + 32'd1;
        end
        #2 n_rst = 1'b0;
        #1;
        chk("rst_mid_ctl", {mem_req, busy, is_loaded, err}, 0);
        chk("rst_mid_addr", mem_addr, 0);
        chk("rst_mid_vd", vd_data, 0);
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_quiet", {busy, mem_req, is_loaded, err}, 0);
        end
        chk("rst_quiet_vd", vd_data, 0);
        mem_rvalid = 1'b0;

        do_load(2'd0, 3'b110, 32'h100, 32'h0, '0, 32'd4, 1'b1, '0, 0, 16'h0, 0, dc, we, nh, nr, un, pu);
        chk("reissue_cyc", dc, 5);
        chk("reissue_vd", vd_data, mk_exp(3'b110, 4'hF, 32'h101, 32'h105, 32'h109, 32'h10D));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_load_sequencer.md
# vec_load_sequencer

Parametrised multi-element vector load engine for the vector co-processor. It replaces the single-beat load path with a sequenced one that supports unit-stride, strided and indexed modes, 8/16/32-bit element widths, `vl`-bounded loads and v0 masking. It generates one memory request per active element under a request/valid handshake and assembles the results into a VLEN-wide destination value. It then pulses `is_loaded` toward the register-file write path.

## Interface
Parameters:
- `XLEN`, 32, scalar/address width.
- `VLEN`, 512, vector register width in bits; must be a multiple of 32.
- `MEM_DW`, 32, memory read-data width; must be at least 32.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `mode`  in  2  00 unit-stride, 01 strided, 10 indexed, 11 illegal.
- `width`  in  3  element width: 000 = 8b, 101 = 16b, 110 = 32b; other codes are illegal.
- `base_addr`  in  XLEN  base address (rs1).
- `stride`  in  XLEN  byte stride (rs2), strided mode only.
- `index_data`  in  VLEN  vs2 contents; element i is the unsigned byte offset in indexed mode.
- `vl`  in  XLEN  number of elements to load.
- `vm`  in  1  1 = unmasked, 0 = masked by `v0_mask`.
- `v0_mask`  in  VLEN  mask bit i enables element i.
- `old_vd`  in  VLEN  current destination contents.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  XLEN  element byte address.
- `mem_rvalid`  in  1  read data valid for the current request.
- `mem_rdata`  in  MEM_DW  read data; element is right-aligned in the low bits.
- `busy`  out  1  high from the cycle after `start` until IDLE is re-entered.
- `is_loaded`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle illegal-encoding pulse.
- `vd_data`  out  VLEN  assembled destination value.

## Operation
- Derived values:
  - `eew` = 8/16/32 from `width`.
  - `nelem` = VLEN/eew.
  - `evl` = min(`vl`, `nelem`).
- **Capture on start.** When `start` is high in IDLE, all inputs are captured. `vd_data` is preloaded with `old_vd`, the element index `i` is set to 0, and the address accumulator is set to `base_addr`.
- **States.** IDLE, LOAD, DONE, ERR.
- **IDLE transitions:**
  - `start` with illegal `mode` or `width` → ERR.
  - `start` with `evl` == 0 → DONE.
  - any other `start` → LOAD.
- **LOAD, one element at a time (index i):**
  - Element i is active when `vm` = 1 or `v0_mask[i]` = 1.
  - Inactive element: no request is made. i advances after one cycle, and the `vd_data` slice keeps its `old_vd` value.
  - Active element: `mem_req` = 1 and `mem_addr` is held stable until `mem_rvalid`. On the edge where `mem_req` and `mem_rvalid` are both high, `vd_data[i*eew +: eew]` ← `mem_rdata[eew-1:0]` and i advances.
  - When the last element (i = `evl`−1) completes, the next state is DONE.
- **Addressing** (all arithmetic modulo 2^XLEN):
  - Unit-stride: `base_addr` + i·(eew/8).
  - Strided: `base_addr` + i·`stride`. This uses an accumulator that adds `stride` once per element, including skipped elements.
  - Indexed: `base_addr` + zero-extended `index_data[i*eew +: eew]`.
- **Tail and masked-off elements.** Elements i ≥ `evl` and masked-off elements keep their `old_vd` values (undisturbed policy).
- **DONE.** `is_loaded` = 1 for one cycle, then the block returns to IDLE.
- **ERR.** `err` = 1 for one cycle, then IDLE. No memory access is made, `vd_data` = `old_vd`, and `is_loaded` stays 0.
- **Result hold.** `vd_data` holds its value until the next accepted `start`.
- **`start` outside IDLE** is ignored.
- **`mem_rvalid` without `mem_req`** is ignored.

## Timing
- Reset (asynchronous, `n_rst` low):
  - State goes to IDLE.
  - `mem_req`, `busy`, `is_loaded` and `err` go to 0.
  - `mem_addr` and `vd_data` go to 0.
- Reset during LOAD drops `mem_req` immediately. Any in-flight response after reset release is ignored.
- `start` accepted at edge 0: `busy` = 1 from cycle 1.
- With zero-wait memory (`mem_rvalid` high in the same cycle as `mem_req`), each element, active or skipped, costs exactly 1 cycle. LOAD occupies cycles 1..`evl` and `is_loaded` is high in cycle `evl`+1.
- Each wait cycle on `mem_rvalid` adds one cycle. Only one request is outstanding at a time.
- `vl` = 0: `is_loaded` is high in cycle 1 with no requests.
- Illegal encoding: `err` is high in cycle 1.
- `busy` falls in the cycle after the DONE or ERR cycle. A new `start` is accepted on that cycle's edge.
- `mem_addr`, `mem_req` and `vd_data` are driven from registers (no combinational path from inputs).

## Test plan
- **Unit-stride, 32-bit:** `mode`=00, `width`=110, `base_addr`=0x100, `vl`=4, `vm`=1, zero-wait memory returning addr+1 → `mem_addr` sequence 0x100, 0x104, 0x108, 0x10C; elements 0..3 = 0x101, 0x105, 0x109, 0x10D; remaining elements equal `old_vd`; `is_loaded` in cycle 5.
- **Strided, 8-bit, masked:** `stride`=3, `base_addr`=0x20, `vl`=4, `vm`=0, `v0_mask`=0b0101 → requests only at 0x20 and 0x26; bytes 1 and 3 keep `old_vd`; `is_loaded` in cycle 5.
- **Indexed, 16-bit, memory stall:** index elements 0x10, 0x02, `base_addr`=0x1000, `vl`=2, `mem_rvalid` delayed 2 cycles per request → addresses 0x1010 then 0x1002, each held stable for 3 cycles; `is_loaded` in cycle 7.
- **Boundaries:** `vl`=0 → no `mem_req`, `vd_data`=`old_vd`, `is_loaded` in cycle 1. `vl`=1000 with `width`=110 → exactly 16 elements loaded (`evl` clamped to `nelem`).
- **Illegal encodings:** `width`=011 → `err` pulse in cycle 1, no `mem_req`, no `is_loaded`. `mode`=11 → same behaviour.
- **Reset and re-issue:** `n_rst` low during the 3rd element → outputs go to 0 immediately. A `start` asserted while `busy` is ignored (no second load).
